mult_share_sched: RTL and testbench

- Round-robin scheduler that shares one sequential shift-and-add multiplier (start/valid handshake, 2N-bit product) among NREQ requesters.
- Selects a requester, latches its operands, pulses the multiplier start, and waits for valid under a watchdog. It then returns the product to the granted requester with a done pulse.
- Sits between the requesting datapath units and the single multiplier instance.

---
 rtl/mult_share_sched.sv | 152 +++++++++++++++
 tb/tb_mult_share_sched.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/mult_share_sched.sv
// mult_share_sched
//   Round-robin scheduler sharing one sequential multiplier (start/valid
//   handshake, 2N-bit product) among NREQ requesters. A winner is picked
//   from req starting at the rotating pointer. Its operands are latched
//   and the multiplier is started. The scheduler then waits for mul_valid
//   under a watchdog and returns the product with a one-hot done pulse.
//
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   req                 per-requester request level
//   a_in, b_in          packed operands, slice i = [i*N +: N]
//   gnt                 one-hot pulse: operands of requester i accepted
//   done                one-hot pulse: result valid for requester i
//   result              product of last completed job (0 on timeout)
//   err                 pulse with done when the job timed out
//   busy                high in every state except IDLE
//   mul_start           start pulse to the multiplier
//   mul_multiplier      latched operand A
//   mul_multiplicand    latched operand B
//   mul_product         multiplier product
//   mul_valid           multiplier completion pulse
module mult_share_sched #(
  parameter int N       = 32,
  parameter int NREQ    = 4,
  parameter int TIMEOUT = 256
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*N-1:0] a_in,
  input  logic [NREQ*N-1:0] b_in,
  output logic [NREQ-1:0]   gnt,
  output logic [NREQ-1:0]   done,
  output logic [2*N-1:0]    result,
  output logic              err,
  output logic              busy,
  output logic              mul_start,
  output logic [N-1:0]      mul_multiplier,
  output logic [N-1:0]      mul_multiplicand,
  input  logic [2*N-1:0]    mul_product,
  input  logic              mul_valid
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int WW = $clog2(TIMEOUT + 1);
  localparam logic [WW-1:0] WDOG_LAST = WW'(TIMEOUT - 1);
  localparam logic [PW-1:0] LAST_IDX  = PW'(NREQ - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  state_t          state;
  logic [PW-1:0]   ptr;
  logic [PW-1:0]   cur;
  logic [PW-1:0]   win;
  logic            hit;
  logic [WW-1:0]   wdog;
  logic [N-1:0]    a_sel;
  logic [N-1:0]    b_sel;

  function automatic logic [NREQ-1:0] onehot(input logic [PW-1:0] i);
    onehot    = '0;
    onehot[i] = 1'b1;
  endfunction

  // Rotating priority: for every possible pointer value the scan order
  // (p+k) mod NREQ is a constant, so the wrap needs no runtime arithmetic.
  always_comb begin
    hit = 1'b0;
    win = '0;
    for (int unsigned p = 0; p < NREQ; p++) begin
      if (ptr == PW'(p)) begin
        for (int unsigned k = 0; k < NREQ; k++) begin
          if (!hit && req[(p + k) % NREQ]) begin
            hit = 1'b1;
            win = PW'((p + k) % NREQ);
          end
        end
      end
    end
  end

  always_comb begin
    a_sel = '0;
    b_sel = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (win == PW'(i)) begin
        a_sel = a_in[i*N +: N];
        b_sel = b_in[i*N +: N];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state            <= IDLE;
      ptr              <= '0;
      cur              <= '0;
      gnt              <= '0;
      done             <= '0;
      err              <= 1'b0;
      busy             <= 1'b0;
      mul_start        <= 1'b0;
      result           <= '0;
      mul_multiplier   <= '0;
      mul_multiplicand <= '0;
      wdog             <= '0;
    end else begin
      gnt       <= '0;
      done      <= '0;
      err       <= 1'b0;
      mul_start <= 1'b0;
      case (state)
        IDLE: begin
          if (hit) begin
            cur              <= win;
            gnt              <= onehot(win);
            mul_multiplier   <= a_sel;
            mul_multiplicand <= b_sel;
            mul_start        <= 1'b1;
            busy             <= 1'b1;
            state            <= ISSUE;
          end
        end
        ISSUE: begin
          wdog  <= '0;
          state <= WAIT;
        end
        WAIT: begin
          wdog <= wdog + WW'(1);
          // A completion in the final watchdog cycle still counts as success.
          if (mul_valid) begin
            result <= mul_product;
            done   <= onehot(cur);
            state  <= DONE;
          end else if (wdog == WDOG_LAST) begin
            result <= '0;
            err    <= 1'b1;
            done   <= onehot(cur);
            state  <= DONE;
          end
        end
        DONE: begin
          ptr   <= (cur == LAST_IDX) ? '0 : cur + PW'(1);
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_share_sched.sv
// Testbench for mult_share_sched: directed sequence with random operands and
// random multiplier latencies. The bench itself acts as the multiplier.
// Expected winners come from a round-robin pick over the request vector.
// Expected products come from plain 64-bit arithmetic on the operands
// the bench drove.
module tb_mult_share_sched;
  localparam int N       = 32;
  localparam int NREQ    = 4;
  localparam int TIMEOUT = 256;

  logic              clk = 1'b0;
  logic              reset;
  logic [NREQ-1:0]   req;
  logic [NREQ*N-1:0] a_in;
  logic [NREQ*N-1:0] b_in;
  logic [NREQ-1:0]   gnt;
  logic [NREQ-1:0]   done;
  logic [2*N-1:0]    result;
  logic              err;
  logic              busy;
  logic              mul_start;
  logic [N-1:0]      mul_multiplier;
  logic [N-1:0]      mul_multiplicand;
  logic [2*N-1:0]    mul_product;
  logic              mul_valid;

  mult_share_sched #(.N(N), .NREQ(NREQ), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset), .req(req), .a_in(a_in), .b_in(b_in),
    .gnt(gnt), .done(done), .result(result), .err(err), .busy(busy),
    .mul_start(mul_start), .mul_multiplier(mul_multiplier),
    .mul_multiplicand(mul_multiplicand), .mul_product(mul_product),
    .mul_valid(mul_valid)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int ptr_m  = 0;
  int last_w = 0;
  logic [63:0] last_res = '0;
  logic [N-1:0] a_m [NREQ];
  logic [N-1:0] b_m [NREQ];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int pick(input logic [NREQ-1:0] r, input int p);
    for (int k = 0; k < NREQ; k++)
      if (r[(p + k) % NREQ]) return (p + k) % NREQ;
    return -1;
  endfunction

  task automatic set_req(input int i, input logic [N-1:0] a, input logic [N-1:0] b);
    req[i] = 1'b1;
    a_in[i*N +: N] = a;
    b_in[i*N +: N] = b;
    a_m[i] = a;
    b_m[i] = b;
  endtask

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_gnt"}, 64'(gnt), 64'(0));
    chk({tag, "_done"}, 64'(done), 64'(0));
    chk({tag, "_err"}, 64'(err), 64'(0));
    chk({tag, "_busy"}, 64'(busy), 64'(0));
    chk({tag, "_start"}, 64'(mul_start), 64'(0));
    chk({tag, "_result"}, result, 64'(0));
    chk({tag, "_opa"}, 64'(mul_multiplier), 64'(0));
    chk({tag, "_opb"}, 64'(mul_multiplicand), 64'(0));
  endtask

  // Runs one job from the current IDLE negedge.
  // d >= 0: mul_valid is sampled in WAIT cycle d+1; d < 0: never.
  // late >= 0: that requester raises req mid-job.
  // rearm: the winner re-raises req (new operands) once its done is seen.
  task automatic do_job(input int d, input int late, input bit rearm, input string tag);
    int w;
    int n;
    logic [NREQ-1:0] oh;
    logic [63:0] prod;
    w = pick(req, ptr_m);
    chk({tag, "_pending"}, 64'(w >= 0), 64'(1));
    if (w < 0) w = 0;
    oh = '0;
    oh[w] = 1'b1;
    prod = {32'b0, a_m[w]} * {32'b0, b_m[w]};
    n = 0;
    @(negedge clk);
    while (gnt == '0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_gnt"}, 64'(gnt), 64'(oh));
    chk({tag, "_start"}, 64'(mul_start), 64'(1));
    chk({tag, "_busy"}, 64'(busy), 64'(1));
    chk({tag, "_opa"}, 64'(mul_multiplier), 64'(a_m[w]));
    chk({tag, "_opb"}, 64'(mul_multiplicand), 64'(b_m[w]));
    req[w] = 1'b0;
    if (late >= 0) set_req(late, $urandom, $urandom);
    if (d >= 0) begin
      repeat (d + 1) @(negedge clk);
      chk({tag, "_early_done"}, 64'(done), 64'(0));
      chk({tag, "_start_once"}, 64'(mul_start), 64'(0));
      mul_valid   = 1'b1;
      mul_product = prod;
      @(negedge clk);
      mul_valid   = 1'b0;
      mul_product = {$urandom, $urandom};
      chk({tag, "_done"}, 64'(done), 64'(oh));
      chk({tag, "_err"}, 64'(err), 64'(0));
      chk({tag, "_result"}, result, prod);
      last_res = prod;
    end else begin
      n = 0;
      while (done == '0 && n < TIMEOUT + 20) begin
        @(negedge clk);
        n++;
      end
      chk({tag, "_to_latency"}, 64'(n), 64'(TIMEOUT + 1));
      chk({tag, "_done"}, 64'(done), 64'(oh));
      chk({tag, "_err"}, 64'(err), 64'(1));
      chk({tag, "_result"}, result, 64'(0));
      last_res = '0;
    end
    chk({tag, "_busy_done"}, 64'(busy), 64'(1));
    chk({tag, "_no_gnt"}, 64'(gnt), 64'(0));
    ptr_m  = (w + 1) % NREQ;
    last_w = w;
    if (rearm) set_req(w, $urandom, $urandom);
    @(negedge clk);
    chk({tag, "_done_clr"}, 64'(done), 64'(0));
    chk({tag, "_err_clr"}, 64'(err), 64'(0));
    chk({tag, "_idle"}, 64'(busy), 64'(0));
  endtask

  initial begin
    int n;
    logic seen;
    reset = 1'b1;
    req = '0;
    a_in = '0;
    b_in = '0;
    mul_valid = 1'b0;
    mul_product = '0;
    for (int i = 0; i < NREQ; i++) begin
      a_m[i] = '0;
      b_m[i] = '0;
    end
    repeat (2) @(negedge clk);
    check_idle_outputs("reset");
    reset = 1'b0;
    @(negedge clk);

    // Single request, small operands.
    set_req(0, 32'd3, 32'd5);
    do_job(2, -1, 1'b0, "single");
    chk("single_value", result, 64'd15);

    // Full-width operands.
    set_req(1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    do_job(5, -1, 1'b0, "full");
    chk("full_value", result, 64'hFFFF_FFFE_0000_0001);

    // Reset between jobs so the rotation starts at requester 0.
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    ptr_m = 0;

    // Round-robin with every requester continuously re-requesting.
    for (int i = 0; i < NREQ; i++) set_req(i, $urandom, $urandom);
    for (int j = 0; j < 8; j++) begin
      do_job(int'($urandom_range(0, 12)), -1, 1'b1, "rr");
      chk("rr_order", 64'(last_w), 64'(j % NREQ));
    end
    req = '0;
    @(negedge clk);

    // Contention: requester 2 arrives while requester 0 is in WAIT.
    set_req(0, $urandom, $urandom);
    do_job(3, 2, 1'b0, "cont_a");
    do_job(1, -1, 1'b0, "cont_b");
    chk("cont_winner", 64'(last_w), 64'(2));

    // Stray completion in IDLE must not touch result.
    mul_valid = 1'b1;
    mul_product = {$urandom, $urandom};
    @(negedge clk);
    mul_valid = 1'b0;
    @(negedge clk);
    chk("stray_result", result, last_res);
    chk("stray_done", 64'(done), 64'(0));
    chk("stray_busy", 64'(busy), 64'(0));

    // Timeout, then completion in the very last watchdog cycle.
    set_req(3, $urandom, $urandom);
    do_job(-1, -1, 1'b0, "timeout");
    set_req(0, $urandom, $urandom);
    do_job(TIMEOUT - 1, -1, 1'b0, "last_cycle");

    // Reset during WAIT aborts silently and restarts the rotation at 0.
    set_req(1, $urandom, $urandom);
    n = 0;
    @(negedge clk);
    while (gnt == '0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("rst_gnt", 64'(gnt), 64'(4'b0010));
    req[1] = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check_idle_outputs("rst_wait");
    reset = 1'b0;
    seen = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (done != '0 || err || gnt != '0) seen = 1'b1;
    end
    chk("rst_quiet", 64'(seen), 64'(0));
    ptr_m = 0;
    set_req(0, $urandom, $urandom);
    set_req(1, $urandom, $urandom);
    set_req(3, $urandom, $urandom);
    do_job(4, -1, 1'b0, "after_rst");
    chk("after_rst_winner", 64'(last_w), 64'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
